// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants, source-index type and grant helpers used
//                by the round-robin arbiter and its request queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef logic [IDX_W-1:0] req_idx_t;

   // True when exactly one bit of the vector is set.
   function automatic logic is_onehot(input logic [N_REQ-1:0] vec);
      return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
   endfunction

   // OR-reduction encoder; only meaningful for a one-hot input.
   function automatic req_idx_t onehot_to_idx(input logic [N_REQ-1:0] vec);
      req_idx_t idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i]) begin
            idx = idx | req_idx_t'(i);
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : req_fifo
//  Description : Single-writer/single-reader synchronous FIFO holding queued
//                requests for one arbiter client.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;

   logic w_rd;
   logic w_wr;

   assign full  = (r_count == c_full_cnt);
   assign empty = (r_count == '0);
   assign rdata = r_mem[r_rptr];

   // A write while full still lands when the head leaves in the same cycle.
   assign w_rd = pop && !empty;
   assign w_wr = push && (!full || w_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_rd) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/arb_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : arb_req_queue
//  Description : Per-client request FIFOs feeding a 4-way arbiter; pops the
//                granted head onto a registered output and flags bad grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_req_queue
   import arb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        in_valid,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   output logic [N_REQ-1:0]        in_ready,
   output logic [N_REQ-1:0]        Req,
   input  logic [N_REQ-1:0]        Grant,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output req_idx_t                out_src,
   output logic                    grant_err
);

   logic [N_REQ-1:0]  w_full;
   logic [N_REQ-1:0]  w_empty;
   logic [N_REQ-1:0]  w_req;
   logic [N_REQ-1:0]  w_pop;
   logic [DATA_W-1:0] w_rdata [N_REQ];
   logic              w_legal;
   logic              w_illegal;
   req_idx_t          w_idx;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   req_idx_t          r_out_src;
   logic              r_grant_err;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fifo
      req_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (in_valid[gi]),
         .pop   (w_pop[gi]),
         .wdata (in_data[gi*DATA_W +: DATA_W]),
         .rdata (w_rdata[gi]),
         .full  (w_full[gi]),
         .empty (w_empty[gi])
      );
   end

   assign w_req    = ~w_empty;
   assign Req      = w_req;
   assign in_ready = ~w_full;

   // Legality uses registered Req only, so a same-cycle push never satisfies a grant.
   assign w_legal   = is_onehot(Grant) && ((Grant & w_req) == Grant);
   assign w_illegal = (Grant != '0) && !w_legal;
   assign w_idx     = onehot_to_idx(Grant);
   assign w_pop     = w_legal ? Grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_grant_err <= 1'b0;
      end else begin
         r_out_valid <= w_legal;
         if (w_legal) begin
            r_out_data <= w_rdata[w_idx];
            r_out_src  <= w_idx;
         end
         if (w_illegal) begin
            r_grant_err <= 1'b1;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign grant_err = r_grant_err;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_req_queue
//  Description : Scoreboard bench for arb_req_queue with queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_req_queue;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int N     = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  in_valid;
   logic [31:0]   in_data;
   logic [N-1:0]  in_ready;
   logic [N-1:0]  Req;
   logic [N-1:0]  Grant;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_src;
   logic          grant_err;

   arb_req_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .Req       (Req),
      .Grant     (Grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .grant_err (grant_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic [1:0] s;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mq [N][$];
   logic       m_err = 1'b0;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] m_req();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (mq[i].size() != 0);
      return r;
   endfunction

   function automatic logic [N-1:0] m_rdy();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (mq[i].size() < DEPTH);
      return r;
   endfunction

   function automatic logic [31:0] at(input int p, input logic [7:0] b);
      return 32'(b) << (p * 8);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) mq[i].delete();
      sb.delete();
      m_err = 1'b0;
   endtask

   // Reference model: advance queues on each rising edge from the driven inputs.
   initial forever begin
      int         k;
      logic       legal;
      logic [7:0] d;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         clear_model();
      end else begin
         legal = 1'b0;
         k = 0;
         if ($countones(Grant) == 1) begin
            for (int i = 0; i < N; i++) if (Grant[i]) k = i;
            legal = (mq[k].size() > 0);
         end
         if (Grant != '0 && !legal) m_err = 1'b1;
         if (legal) begin
            d = mq[k].pop_front();
            sb.push_back('{cyc, d, 2'(k)});
         end
         for (int i = 0; i < N; i++) begin
            if (in_valid[i] && mq[i].size() < DEPTH) mq[i].push_back(in_data[i*8 +: 8]);
         end
      end
   end

   // Monitor: compare DUT outputs against model state and scoreboard.
   initial forever begin
      exp_t e;
      @(negedge clk);
      chk("req", 32'(Req), 32'(m_req()));
      chk("in_ready", 32'(in_ready), 32'(m_rdy()));
      chk("grant_err", 32'(grant_err), 32'(m_err));
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         chk("out_valid", 32'(out_valid), 32'd1);
         chk("out_data", 32'(out_data), 32'(e.d));
         chk("out_src", 32'(out_src), 32'(e.s));
      end else begin
         chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
   end

   task automatic step(input logic [N-1:0] v, input logic [31:0] d, input logic [N-1:0] g);
      in_valid = v;
      in_data  = d;
      Grant    = g;
      @(negedge clk);
   endtask

   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_req", 32'(Req), 32'h0);
      chk("rst_async_out_valid", 32'(out_valid), 32'h0);
      chk("rst_async_in_ready", 32'(in_ready), 32'hF);
      clear_model();
      in_valid = '0;
      Grant    = '0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] g;
      int           cand[$];
      int           r;

      rst_n    = 1'b0;
      in_valid = 4'hF;
      in_data  = $urandom;
      Grant    = '0;
      repeat (3) begin
         @(negedge clk);
         in_data = $urandom;
         chk("rst_req", 32'(Req), 32'h0);
         chk("rst_in_ready", 32'(in_ready), 32'hF);
         chk("rst_out_valid", 32'(out_valid), 32'h0);
         chk("rst_grant_err", 32'(grant_err), 32'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("req_first_push", 32'(Req), 32'hF);
      for (int n = 0; n < N; n++) step('0, '0, 4'(1 << n));
      step('0, '0, '0);

      // Fill port 2 past capacity, drain with gaps, then wrap the pointers.
      for (int n = 0; n < 5; n++) begin
         step(4'b0100, at(2, 8'(8'h10 + n)), '0);
         if (n == 3) chk("fill_in_ready", 32'(in_ready), 32'hB);
      end
      chk("fill_req", 32'(Req), 32'h4);
      for (int n = 0; n < 4; n++) begin
         step('0, '0, 4'b0100);
         chk("fill_pop_valid", 32'(out_valid), 32'h1);
         chk("fill_pop_data", 32'(out_data), 32'(8'h10 + n));
         chk("fill_pop_src", 32'(out_src), 32'h2);
         step('0, '0, '0);
      end
      chk("fill_drained", 32'(Req), 32'h0);
      step(4'b0100, at(2, 8'h20), '0);
      step('0, '0, 4'b0100);
      chk("wrap_data", 32'(out_data), 32'h20);
      step('0, '0, '0);

      // Push and pop together on a full FIFO.
      for (int n = 0; n < 4; n++) step(4'b0001, at(0, 8'(8'hA0 + n)), '0);
      chk("full0_in_ready", 32'(in_ready), 32'hE);
      step(4'b0001, at(0, 8'hAA), 4'b0001);
      chk("simul_data", 32'(out_data), 32'hA0);
      chk("simul_still_full", 32'(in_ready), 32'hE);
      for (int n = 0; n < 4; n++) begin
         step('0, '0, 4'b0001);
         chk("simul_drain", 32'(out_data), (n == 3) ? 32'hAA : 32'(8'hA1 + n));
      end
      step('0, '0, '0);

      // One entry per port, granted in rotation.
      step(4'hF, 32'h33323130, '0);
      for (int n = 0; n < N; n++) begin
         step('0, '0, 4'(1 << n));
         chk("rr_src", 32'(out_src), 32'(n));
         chk("rr_data", 32'(out_data), 32'(8'h30 + n));
         chk("rr_req", 32'(Req), (32'hF << (n + 1)) & 32'hF);
      end
      step('0, '0, '0);

      // Illegal grants.
      step(4'b0011, 32'h0000_4241, '0);
      step('0, '0, 4'b0011);
      chk("multi_grant_err", 32'(grant_err), 32'h1);
      chk("multi_grant_no_pop", 32'(out_valid), 32'h0);
      chk("multi_grant_req", 32'(Req), 32'h3);
      reset_mid();
      chk("err_cleared", 32'(grant_err), 32'h0);
      step('0, '0, 4'b1000);
      chk("empty_grant_err", 32'(grant_err), 32'h1);
      chk("empty_grant_no_pop", 32'(out_valid), 32'h0);
      reset_mid();

      // Reset while entries are queued and an output is in flight.
      for (int n = 0; n < 4; n++) step(4'b0010, at(1, 8'(8'h51 + n)), '0);
      step('0, '0, 4'b0010);
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      reset_mid();
      step('0, '0, 4'b0010);
      chk("post_rst_grant_err", 32'(grant_err), 32'h1);
      chk("post_rst_no_pop", 32'(out_valid), 32'h0);
      reset_mid();

      // Randomized traffic.
      for (int it = 0; it < 1500; it++) begin
         r = $urandom_range(0, 199);
         if (r == 0) begin
            reset_mid();
         end else begin
            g = '0;
            r = $urandom_range(0, 99);
            if (r < 55) begin
               cand.delete();
               for (int i = 0; i < N; i++) if (mq[i].size() > 0) cand.push_back(i);
               if (cand.size() > 0) g = 4'(1 << cand[$urandom_range(0, cand.size() - 1)]);
            end else if (r < 58) begin
               g = 4'($urandom);
            end
            step(4'($urandom), $urandom, g);
         end
      end

      step('0, '0, '0);
      step('0, '0, '0);
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
